// File: rtl/stream_minmax.sv
// Streaming extremum tracker: folds a valid/ready frame of samples into its
// minimum or maximum, the first position of that extremum and the frame length.
module stream_minmax #(
    parameter int N      = 8,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_value,
    output logic [CNT_W-1:0] out_index,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [0:0]       ST_ACC  = 1'b0;
    localparam logic [0:0]       ST_DONE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state_q,     state_d;
    logic             mode_q,      mode_d;
    logic [N-1:0]     best_q,      best_d;
    logic [CNT_W-1:0] best_idx_q,  best_idx_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;
    logic [N-1:0]     res_value_q, res_value_d;
    logic [CNT_W-1:0] res_index_q, res_index_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_ovf_q,   res_ovf_d;

    logic             accept_s;
    logic [N-1:0]     nb_best_s;
    logic [CNT_W-1:0] nb_idx_s;
    logic [CNT_W-1:0] nb_cnt_s;
    logic             nb_ovf_s;
    logic             nb_mode_s;

    // Strict improvement test; ties return 0 so the earliest sample is kept.
    function automatic logic is_better(input logic [N-1:0] cand,
                                       input logic [N-1:0] cur,
                                       input logic        track_max);
        logic lt_v;
        logic gt_v;
        if (SIGNED != 0) begin
            lt_v = ($signed(cand) < $signed(cur));
            gt_v = ($signed(cand) > $signed(cur));
        end else begin
            lt_v = (cand < cur);
            gt_v = (cand > cur);
        end
        return track_max ? gt_v : lt_v;
    endfunction

    assign accept_s = in_valid && (state_q == ST_ACC);

    // Accumulator update for one accepted beat; cnt_q == 0 marks the frame start.
    always_comb begin
        nb_best_s = best_q;
        nb_idx_s  = best_idx_q;
        nb_cnt_s  = cnt_q;
        nb_ovf_s  = ovf_q;
        nb_mode_s = mode_q;
        if (cnt_q == {CNT_W{1'b0}}) begin
            nb_best_s = in_data;
            nb_idx_s  = {CNT_W{1'b0}};
            nb_cnt_s  = CNT_ONE;
            nb_ovf_s  = 1'b0;
            nb_mode_s = mode;
        end else begin
            // Once saturated cnt_q is all-ones, which is exactly the index to store.
            if (is_better(in_data, best_q, mode_q)) begin
                nb_best_s = in_data;
                nb_idx_s  = cnt_q;
            end else begin
                nb_idx_s  = best_idx_q;
            end
            if (cnt_q == CNT_MAX) begin
                nb_ovf_s = 1'b1;
            end else begin
                nb_cnt_s = cnt_q + CNT_ONE;
            end
        end
    end

    // Next-state, accumulator and result register selection.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_value_d = res_value_q;
        res_index_d = res_index_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;
        if (accept_s) begin
            mode_d     = nb_mode_s;
            best_d     = nb_best_s;
            best_idx_d = nb_idx_s;
            ovf_d      = nb_ovf_s;
            if (in_last) begin
                state_d     = ST_DONE;
                cnt_d       = {CNT_W{1'b0}};
                res_value_d = nb_best_s;
                res_index_d = nb_idx_s;
                res_count_d = nb_cnt_s;
                res_ovf_d   = nb_ovf_s;
            end else begin
                cnt_d = nb_cnt_s;
            end
        end else if ((state_q == ST_DONE) && out_ready) begin
            state_d = ST_ACC;
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            mode_q      <= 1'b0;
            best_q      <= {N{1'b0}};
            best_idx_q  <= {CNT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            res_value_q <= {N{1'b0}};
            res_index_q <= {CNT_W{1'b0}};
            res_count_q <= {CNT_W{1'b0}};
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_value_q <= res_value_d;
            res_index_q <= res_index_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign out_value = res_value_q;
    assign out_index = res_index_q;
    assign out_count = res_count_q;
    assign out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_stream_minmax.sv
// Bench for stream_minmax: three configurations driven in lockstep and checked
// against table constants and a list-based min/max reference model.
module tb_stream_minmax;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       rdy_u, ov_u, ovf_u;
    logic [7:0] val_u, idx_u, cnt_u;
    logic       rdy_s, ov_s, ovf_s;
    logic [7:0] val_s, idx_s, cnt_s;
    logic       rdy_c, ov_c, ovf_c;
    logic [7:0] val_c;
    logic [2:0] idx_c, cnt_c;

    int total = 0;
    int bad   = 0;
    int fd[$];
    logic fm[$];

    typedef struct {
        int          len;
        logic [63:0] bytes;
        logic        md;
        int          uv, ui, sv, si, cnt;
    } vec_t;
    vec_t vt[6];

    always #5 clk = ~clk;

    stream_minmax #(.N(8), .CNT_W(8), .SIGNED(0)) u_u8 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_u), .out_valid(ov_u), .out_ready(out_ready),
        .out_value(val_u), .out_index(idx_u), .out_count(cnt_u), .out_ovf(ovf_u));
    stream_minmax #(.N(8), .CNT_W(8), .SIGNED(1)) u_s8 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_s), .out_valid(ov_s), .out_ready(out_ready),
        .out_value(val_s), .out_index(idx_s), .out_count(cnt_s), .out_ovf(ovf_s));
    stream_minmax #(.N(8), .CNT_W(3), .SIGNED(0)) u_c3 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_c), .out_valid(ov_c), .out_ready(out_ready),
        .out_value(val_c), .out_index(idx_c), .out_count(cnt_c), .out_ovf(ovf_c));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: extremum of a sample list, first occurrence, saturating counts.
    function automatic void model(input int d[$], input logic md, input bit sgn,
                                  input int cw, output int v, output int ix,
                                  output int c, output int o);
        int maxc = (1 << cw) - 1;
        int bi = 0;
        int a, b;
        for (int i = 1; i < d.size(); i++) begin
            a = (sgn && d[i] >= 128) ? d[i] - 256 : d[i];
            b = (sgn && d[bi] >= 128) ? d[bi] - 256 : d[bi];
            if (md ? (a > b) : (a < b)) bi = i;
        end
        v  = d[bi];
        ix = (bi > maxc) ? maxc : bi;
        c  = (d.size() > maxc) ? maxc : d.size();
        o  = (d.size() > maxc) ? 1 : 0;
    endfunction

    task automatic check_model(input string tag);
        int v, ix, c, o;
        chk({tag, "_valid"}, int'(ov_u && ov_s && ov_c), 1);
        chk({tag, "_inready"}, int'(rdy_u || rdy_s || rdy_c), 0);
        model(fd, fm[0], 1'b0, 8, v, ix, c, o);
        chk({tag, "_u8_val"}, int'(val_u), v);
        chk({tag, "_u8_idx"}, int'(idx_u), ix);
        chk({tag, "_u8_cnt"}, int'(cnt_u), c);
        chk({tag, "_u8_ovf"}, int'(ovf_u), o);
        model(fd, fm[0], 1'b1, 8, v, ix, c, o);
        chk({tag, "_s8_val"}, int'(val_s), v);
        chk({tag, "_s8_idx"}, int'(idx_s), ix);
        chk({tag, "_s8_cnt"}, int'(cnt_s), c);
        model(fd, fm[0], 1'b0, 3, v, ix, c, o);
        chk({tag, "_c3_val"}, int'(val_c), v);
        chk({tag, "_c3_idx"}, int'(idx_c), ix);
        chk({tag, "_c3_cnt"}, int'(cnt_c), c);
        chk({tag, "_c3_ovf"}, int'(ovf_c), o);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rdy_u && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy_u) chk("ready_timeout", 0, 1);
    endtask

    // Drives fd/fm as one frame; returns one cycle after the last beat's edge.
    task automatic send(input bit bubbles);
        for (int i = 0; i < fd.size(); i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = 8'(fd[i]);
            mode     = fm[i];
            in_last  = (i == fd.size() - 1);
            wait_ready();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        mode     = 1'($urandom_range(0, 1));
    endtask

    task automatic hs_done(input string tag);
        @(posedge clk); #1;
        chk({tag, "_hs_valid"}, int'(ov_u || ov_s || ov_c), 0);
        chk({tag, "_hs_ready"}, int'(rdy_u && rdy_s && rdy_c), 1);
    endtask

    task automatic load(input int n, input logic [63:0] by, input logic md);
        logic [63:0] b = by;
        fd.delete();
        fm.delete();
        for (int i = 0; i < n; i++) begin
            fd.push_back(int'(b[8*i +: 8]));
            fm.push_back(md);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{5, 64'h00000005_09020903, 1'b1, 9, 1, 9, 1, 5};
        vt[1] = '{4, 64'h00000000_807FF005, 1'b0, 5, 0, 128, 3, 4};
        vt[2] = '{1, 64'h00000000_00000042, 1'b0, 66, 0, 66, 0, 1};
        vt[3] = '{3, 64'h00000000_00070707, 1'b1, 7, 0, 7, 0, 3};
        vt[4] = '{5, 64'h0000001E_0505140A, 1'b0, 5, 2, 5, 2, 5};
        vt[5] = '{3, 64'h00000000_00FF7F80, 1'b1, 255, 2, 127, 1, 3};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", int'(ov_u), 0);
        chk("rst_ready", int'(rdy_u && rdy_s && rdy_c), 1);
        chk("rst_val", int'(val_u) + int'(idx_u) + int'(cnt_u) + int'(ovf_u), 0);

        for (int k = 0; k < 6; k++) begin
            load(vt[k].len, vt[k].bytes, vt[k].md);
            send(1'b0);
            chk($sformatf("vec%0d_u8_val", k), int'(val_u), vt[k].uv);
            chk($sformatf("vec%0d_u8_idx", k), int'(idx_u), vt[k].ui);
            chk($sformatf("vec%0d_s8_val", k), int'(val_s), vt[k].sv);
            chk($sformatf("vec%0d_s8_idx", k), int'(idx_s), vt[k].si);
            chk($sformatf("vec%0d_cnt", k), int'(cnt_u), vt[k].cnt);
            check_model($sformatf("vec%0d", k));
            hs_done($sformatf("vec%0d", k));
        end

        // Back-pressure on a single-beat frame; a new beat offered meanwhile is ignored.
        load(1, 64'h42, 1'b0);
        out_ready = 1'b0;
        send(1'b0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_val", int'(val_u), 66);
            chk("bp_idx", int'(idx_u), 0);
            chk("bp_cnt", int'(cnt_u), 1);
            chk("bp_valid", int'(ov_u), 1);
            chk("bp_ready", int'(rdy_u), 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        hs_done("bp");
        load(2, 64'h0201, 1'b1);
        send(1'b0);
        chk("bp_next_val", int'(val_u), 2);
        chk("bp_next_idx", int'(idx_u), 1);
        check_model("bp_next");
        hs_done("bp_next");

        // Mode is taken from the first beat only.
        fd = '{7, 3, 8};
        fm = '{1'b0, 1'b1, 1'b1};
        send(1'b0);
        chk("ml_val", int'(val_u), 3);
        chk("ml_idx", int'(idx_u), 1);
        check_model("ml");
        hs_done("ml");

        // Saturation: 9 beats 0..8 through the 3-bit counter.
        fd.delete();
        fm.delete();
        for (int i = 0; i < 9; i++) begin
            fd.push_back(i);
            fm.push_back(1'b1);
        end
        send(1'b0);
        chk("sat_c3_val", int'(val_c), 8);
        chk("sat_c3_idx", int'(idx_c), 7);
        chk("sat_c3_cnt", int'(cnt_c), 7);
        chk("sat_c3_ovf", int'(ovf_c), 1);
        chk("sat_u8_idx", int'(idx_u), 8);
        chk("sat_u8_cnt", int'(cnt_u), 9);
        chk("sat_u8_ovf", int'(ovf_u), 0);
        check_model("sat");
        hs_done("sat");

        // Reset mid-frame, held while a last beat is offered.
        in_valid = 1'b1; in_last = 1'b0; mode = 1'b0; in_data = 8'd4;
        @(posedge clk); #1;
        in_data = 8'd1;
        @(posedge clk); #1;
        rst = 1'b1; in_data = 8'd0; in_last = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("mrst_valid", int'(ov_u || ov_s || ov_c), 0);
        chk("mrst_ready", int'(rdy_u && rdy_s && rdy_c), 1);
        chk("mrst_out", int'(val_u) + int'(idx_u) + int'(cnt_u) + int'(ovf_u)
                        + int'(val_c) + int'(cnt_c), 0);
        fd = '{6, 2};
        fm = '{1'b0, 1'b0};
        send(1'b0);
        chk("mrst_val", int'(val_u), 2);
        chk("mrst_idx", int'(idx_u), 1);
        chk("mrst_cnt", int'(cnt_u), 2);
        check_model("mrst");
        hs_done("mrst");

        // Randomized frames with bubbles, mid-frame mode noise and stalls.
        for (int f = 0; f < 30; f++) begin
            int len = $urandom_range(1, 12);
            fd.delete();
            fm.delete();
            for (int i = 0; i < len; i++) begin
                fd.push_back($urandom_range(0, 1) ? $urandom_range(0, 255)
                                                  : 126 + $urandom_range(0, 3));
                fm.push_back(1'($urandom_range(0, 1)));
            end
            send(1'b1);
            out_ready = 1'b0;
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                check_model($sformatf("rnd%0d_stall", f));
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            check_model($sformatf("rnd%0d", f));
            hs_done($sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
